// File: rtl/sin_dds_pkg.sv
// ============================================================================
// Module      : sin_dds_pkg
// Description : Shared widths, quadrant encoding and table constants for the
//               quarter-wave sine DDS.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sin_dds_pkg;

   localparam int DEF_PHASE_WIDTH = 16;
   localparam int DEF_ADR_WIDTH   = 8;
   localparam int DEF_DATA_WIDTH  = 8;

   // Largest address of the default-size quarter-wave table.
   localparam int TBL_MAX_ADDR    = (1 << DEF_ADR_WIDTH) - 1;

   // Top two phase bits select the quadrant of the full sine period.
   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } quad_t;

endpackage : sin_dds_pkg

`default_nettype wire

// File: rtl/sin_dds_fold.sv
// ============================================================================
// Module      : sin_dds_fold
// Description : Combinational quadrant fold, phase accumulator -> table
//               address and output sign. Behaviour selected by the
//               SIN_DDS_FULLWAVE_EN macro (undefined: quarter-wave sweep).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sin_dds_fold
   import sin_dds_pkg::*;
#(
   parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
   parameter int ADR_WIDTH   = DEF_ADR_WIDTH
) (
   input  logic [PHASE_WIDTH-1:0] acc_i,
   output logic [ADR_WIDTH-1:0]   addr_o,
   output logic                   sign_o
);

`ifdef SIN_DDS_FULLWAVE_EN

   localparam logic [ADR_WIDTH-1:0] MAX_ADDR = {ADR_WIDTH{1'b1}};

   quad_t                quad;
   logic [ADR_WIDTH-1:0] field;

   assign quad  = quad_t'(acc_i[PHASE_WIDTH-1 -: 2]);
   assign field = acc_i[PHASE_WIDTH-3 -: ADR_WIDTH];

   // Odd quadrants run the table backwards; the upper half period is negated.
   always_comb begin
      addr_o = field;
      sign_o = 1'b0;
      unique case (quad)
         Q0: begin
            addr_o = field;
            sign_o = 1'b0;
         end
         Q1: begin
            addr_o = MAX_ADDR - field;
            sign_o = 1'b0;
         end
         Q2: begin
            addr_o = field;
            sign_o = 1'b1;
         end
         Q3: begin
            addr_o = MAX_ADDR - field;
            sign_o = 1'b1;
         end
         default: begin
            addr_o = field;
            sign_o = 1'b0;
         end
      endcase
   end

   if (PHASE_WIDTH > ADR_WIDTH + 2) begin : g_trunc
      logic unused_lsbs;
      assign unused_lsbs = ^acc_i[PHASE_WIDTH-ADR_WIDTH-3:0];
   end

`else

   assign addr_o = acc_i[PHASE_WIDTH-1 -: ADR_WIDTH];
   assign sign_o = 1'b0;

   logic unused_lsbs;
   assign unused_lsbs = ^acc_i[PHASE_WIDTH-ADR_WIDTH-1:0];

`endif

endmodule : sin_dds_fold

`default_nettype wire

// File: rtl/sin_dds.sv
// ============================================================================
// Module      : sin_dds
// Description : Phase-accumulator sine DDS driving an external registered
//               quarter-wave table. SIN_DDS_FULLWAVE_EN enables quadrant
//               mirroring and sign; undefined gives a quarter-wave sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sin_dds
   import sin_dds_pkg::*;
#(
   parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
   parameter int ADR_WIDTH   = DEF_ADR_WIDTH,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [PHASE_WIDTH-1:0] fcw,
   input  logic                   phase_load,
   input  logic [PHASE_WIDTH-1:0] phase_in,
   output logic                   tbl_rd,
   output logic [ADR_WIDTH-1:0]   tbl_addr,
   input  logic [DATA_WIDTH-1:0]  tbl_data,
   output logic [DATA_WIDTH:0]    sample_out,
   output logic                   sample_valid
);

   logic [PHASE_WIDTH-1:0] acc_q,    acc_d;
   logic                   sign_q,   sign_d;
   logic                   rdv_q,    rdv_d;
   logic [DATA_WIDTH:0]    sample_q, sample_d;
   logic                   valid_q,  valid_d;

   logic                   fold_sign;
   logic [DATA_WIDTH:0]    data_ext;

   sin_dds_fold #(
      .PHASE_WIDTH (PHASE_WIDTH),
      .ADR_WIDTH   (ADR_WIDTH)
   ) u_fold (
      .acc_i  (acc_q),
      .addr_o (tbl_addr),
      .sign_o (fold_sign)
   );

   assign tbl_rd   = en & ~rst;
   assign data_ext = {1'b0, tbl_data};

   // The table read at this edge uses acc_q, so a concurrent load never
   // disturbs the read already being issued.
   always_comb begin
      acc_d    = acc_q;
      sign_d   = fold_sign;
      rdv_d    = en;
      sample_d = sample_q;
      valid_d  = rdv_q;
      if (phase_load) begin
         acc_d = phase_in;
      end else if (en) begin
         acc_d = acc_q + fcw;
      end
      if (rdv_q) begin
         sample_d = sign_q ? -data_ext : data_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         sign_q   <= 1'b0;
         rdv_q    <= 1'b0;
         sample_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         sign_q   <= sign_d;
         rdv_q    <= rdv_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
      end
   end

   assign sample_out   = sample_q;
   assign sample_valid = valid_q;

endmodule : sin_dds

`default_nettype wire

// File: tb/tb_sin_dds.sv
// ============================================================================
// Module      : tb_sin_dds
// Description : Directed scoreboard bench for sin_dds with a 256x8
//               registered-read quarter-wave table model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sin_dds;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] fcw;
   logic        phase_load;
   logic [15:0] phase_in;
   logic        tbl_rd;
   logic [7:0]  tbl_addr;
   logic [7:0]  tbl_data = 8'd0;
   logic [8:0]  sample_out;
   logic        sample_valid;

   int          tbl [256];
   int          checks   = 0;
   int          failures = 0;

   logic [15:0] m_acc;
   logic        m_v1, m_v2;
   logic [8:0]  m_last;
   logic [8:0]  sb_q [$];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tbl_rd) tbl_data <= 8'(tbl[tbl_addr]);
   end

   sin_dds #(
      .PHASE_WIDTH (16),
      .ADR_WIDTH   (8),
      .DATA_WIDTH  (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .fcw          (fcw),
      .phase_load   (phase_load),
      .phase_in     (phase_in),
      .tbl_rd       (tbl_rd),
      .tbl_addr     (tbl_addr),
      .tbl_data     (tbl_data),
      .sample_out   (sample_out),
      .sample_valid (sample_valid)
   );

   function automatic logic [7:0] exp_addr(input logic [15:0] ph);
`ifdef SIN_DDS_FULLWAVE_EN
      logic [7:0] f;
      f = ph[13:6];
      return ph[14] ? (8'd255 - f) : f;
`else
      return ph[15:8];
`endif
   endfunction

   function automatic logic [8:0] exp_sample(input logic [15:0] ph);
      logic [8:0] mag;
      mag = {1'b0, 8'(tbl[exp_addr(ph)])};
`ifdef SIN_DDS_FULLWAVE_EN
      if (ph[15]) mag = -mag;
`endif
      return mag;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: check the combinational outputs, advance the model, then
   // check the registered outputs just after the edge.
   task automatic tick();
      #1;
      chk("tbl_rd", {31'd0, tbl_rd}, {31'd0, en & ~rst});
      if (!rst) chk("tbl_addr", {24'd0, tbl_addr}, {24'd0, exp_addr(m_acc)});
      if (rst) begin
         m_acc  = 16'd0;
         m_v1   = 1'b0;
         m_v2   = 1'b0;
         m_last = 9'd0;
         sb_q.delete();
      end else begin
         if (en) sb_q.push_back(exp_sample(m_acc));
         m_v2 = m_v1;
         m_v1 = en;
         if (phase_load)  m_acc = phase_in;
         else if (en)     m_acc = m_acc + fcw;
      end
      @(posedge clk);
      #1;
      chk("sample_valid", {31'd0, sample_valid}, {31'd0, m_v2});
      if (m_v2 && sb_q.size() > 0) m_last = sb_q.pop_front();
      chk("sample_out", {23'd0, sample_out}, {23'd0, m_last});
   endtask

   task automatic load_and_read(input logic [15:0] ph, input logic [7:0] lit_addr,
                                input logic [8:0] lit_sample);
      phase_load = 1'b1; phase_in = ph; en = 1'b0;
      tick();
      phase_load = 1'b0;
      chk("lit_addr", {24'd0, tbl_addr}, {24'd0, lit_addr});
      en = 1'b1;
      tick();
      en = 1'b0;
      tick();
      chk("lit_sample", {23'd0, sample_out}, {23'd0, lit_sample});
   endtask

   initial begin
      for (int a = 0; a < 256; a++)
         tbl[a] = $rtoi(255.0 * $sin(3.14159265358979 * a / 510.0) + 0.5);
      m_acc = 16'd0; m_v1 = 1'b0; m_v2 = 1'b0; m_last = 9'd0;

      // Reset held two cycles with en high.
      rst = 1'b1; en = 1'b1; fcw = 16'h0040; phase_load = 1'b0; phase_in = 16'h0000;
      tick();
      tick();
      chk("rst_valid", {31'd0, sample_valid}, 32'd0);
      chk("rst_sample", {23'd0, sample_out}, 32'd0);

      // Linear sweep from phase 0.
      rst = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      en = 1'b0;
      tick();
      tick();

      // Quadrant boundaries.
`ifdef SIN_DDS_FULLWAVE_EN
      load_and_read(16'h4000, 8'd255, 9'd255);
      load_and_read(16'h7FC0, 8'd0,   9'd0);
      load_and_read(16'hC000, 8'd255, 9'h101);
      load_and_read(16'h8000, 8'd0,   9'd0);
`else
      load_and_read(16'hC000, 8'd192, {1'b0, 8'(tbl[192])});
      load_and_read(16'h4000, 8'd64,  {1'b0, 8'(tbl[64])});
`endif

      // Accumulator wrap.
      phase_load = 1'b1; phase_in = 16'hFFC0; en = 1'b0; fcw = 16'h0080;
      tick();
      phase_load = 1'b0; en = 1'b1;
      tick();
`ifdef SIN_DDS_FULLWAVE_EN
      chk("wrap_addr", {24'd0, tbl_addr}, 32'd1);
`else
      chk("wrap_addr", {24'd0, tbl_addr}, 32'd0);
`endif
      tick();
      en = 1'b0;
      tick();
      chk("wrap_sign", {31'd0, sample_out[8]}, 32'd0);
      tick();

      // Enable gaps, then load together with en.
      phase_load = 1'b1; phase_in = 16'h0000; fcw = 16'h0040;
      tick();
      phase_load = 1'b0;
      en = 1'b1; tick();
      en = 1'b1; tick();
      en = 1'b0; tick();
      en = 1'b1; tick();
      phase_load = 1'b1; phase_in = 16'h4000; en = 1'b1;
      tick();
      phase_load = 1'b0;
      tick();
      tick();
      fcw = 16'h0100;
      tick();
      tick();
      en = 1'b0;
      tick();
      tick();

      // Mid-stream reset discards in-flight reads.
      en = 1'b1; fcw = 16'h0123;
      tick();
      tick();
      rst = 1'b1; phase_load = 1'b1; phase_in = 16'h5555;
      tick();
      chk("midrst_valid", {31'd0, sample_valid}, 32'd0);
      rst = 1'b0; phase_load = 1'b0;
      tick();
      tick();
      tick();

      // Random mix of enables, loads and frequency changes.
      for (int i = 0; i < 40; i++) begin
         en         = 1'($urandom_range(0, 3) != 0);
         phase_load = 1'($urandom_range(0, 7) == 0);
         phase_in   = 16'($urandom);
         if ($urandom_range(0, 4) == 0) fcw = 16'($urandom);
         tick();
      end
      en = 1'b0; phase_load = 1'b0;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sin_dds

`default_nettype wire

// File: doc/sin_dds.md
SIN_DDS -- requirements
Module: sin_dds

Interface
REQ-001 Parameter PHASE_WIDTH, default 16, phase accumulator width; SHALL be at least ADR_WIDTH+2.
REQ-002 Parameter ADR_WIDTH, default 8, quarter-wave table address width.
REQ-003 Parameter DATA_WIDTH, default 8, unsigned quarter-wave table data width.
REQ-004 clk  input  1  single clock, all state updates on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  advance phase and issue one table read this cycle.
REQ-007 fcw  input  PHASE_WIDTH  frequency control word, unsigned phase increment.
REQ-008 phase_load  input  1  load phase_in into the accumulator.
REQ-009 phase_in  input  PHASE_WIDTH  phase value to load.
REQ-010 tbl_rd  output  1  read strobe to the quarter-wave sine table (1-cycle registered read).
REQ-011 tbl_addr  output  ADR_WIDTH  table address, combinational from the accumulator.
REQ-012 tbl_data  input  DATA_WIDTH  table read data, valid one cycle after tbl_rd.
REQ-013 sample_out  output  DATA_WIDTH+1  signed two's-complement full-wave sample.
REQ-014 sample_valid  output  1  sample_out holds a new sample this cycle.

Function
REQ-015 Accumulator SHALL update at each edge: phase_load=1 -> phase_in; else en=1 -> acc+fcw mod 2^PHASE_WIDTH; else hold.
REQ-016 phase_load SHALL take priority over en; a simultaneous read SHALL still use the pre-load accumulator value.
REQ-017 Quadrant q = acc[PW-1:PW-2]; field f = acc[PW-3 -: ADR_WIDTH]; lower bits are truncated.
REQ-018 tbl_addr SHALL be f when q[0]=0, and (2^ADR_WIDTH-1)-f when q[0]=1.
REQ-019 tbl_rd SHALL equal en while rst=0, and 0 while rst=1.
REQ-020 Sign q[1] and en SHALL be delayed one cycle to align with tbl_data.
REQ-021 At the edge after data returns, sample_out SHALL become -tbl_data if the delayed sign is 1, else +tbl_data, zero-extended before negation.
REQ-022 Latency: a read issued at edge N SHALL produce sample_valid=1 and its sample after edge N+1, which is 2 cycles.
REQ-023 sample_valid SHALL be en delayed 2 cycles; sample_out SHALL hold its value while sample_valid=0.
REQ-024 Negation SHALL not overflow: the range is -(2^DW-1)..+(2^DW-1), and -0 SHALL yield 0.
REQ-025 fcw changes SHALL take effect at the next accumulate edge, with no pipeline flush.

Reset
REQ-026 On an edge with rst=1: accumulator=0, delayed sign=0, delayed valids=0, sample_out=0, sample_valid=0.
REQ-027 rst mid-stream SHALL discard all in-flight reads; sample_valid SHALL be 0 from the first reset edge.
REQ-028 rst SHALL override phase_load and en.

Configuration
REQ-029 Macro SIN_DDS_FULLWAVE_EN defined: quadrant mirroring and sign SHALL apply per REQ-017 to REQ-021.
REQ-030 Macro undefined: tbl_addr = acc[PW-1 -: ADR_WIDTH], and sample_out = {1'b0, tbl_data}, always non-negative (quarter-wave sweep only).
REQ-031 Latency, handshake and reset behaviour SHALL be identical in both builds.

Structure
REQ-032 Shared package SHALL hold the default widths, the quadrant encoding constants (Q0..Q3) and the table max-address constant.
REQ-033 One sub-module, sin_dds_fold, SHALL contain the combinational quadrant fold (acc -> addr, sign).
REQ-034 The table itself SHALL be external; the bench SHALL connect a 256x8 registered-read model.

Verification (PW=16, ADR=8, DW=8, table[a]=round(255*sin(pi*a/510)), fullwave on unless stated)
REQ-035 rst=1 for 2 cycles with en=1 -> tbl_rd=0, sample_valid=0, sample_out=0; after rst release, first sample_valid at edge 2.
REQ-036 Load 0x0000, fcw=0x0040, en=1 -> tbl_addr 0,1,2,...; sample_out sequence table[0], table[1], ... with 2-cycle lag.
REQ-037 Load 0x4000 -> tbl_addr=255, sample=+255; load 0x7FC0 -> addr=0, sample=0; load 0xC000 -> addr=255, sample=-255.
REQ-038 Wrap: acc=0xFFC0, fcw=0x0080 -> next acc=0x0040, tbl_addr=1, sign positive.
REQ-039 en=1,1,0,1 pattern -> accumulator holds on the en=0 edge; sample_valid=1,1,0,1 delayed 2 cycles; phase_load with en at the same edge -> old-phase sample is emitted, and the next sample uses phase_in.
REQ-040 SIN_DDS_FULLWAVE_EN undefined, load 0xC000 -> tbl_addr=192, sample_out=+table[192].
